// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for the NxN output-stationary PE array: clear, skewed A/B feed, drain, row readout.
// Latency start->done is k_len+3N with res_ready high; readout stalls indefinitely while res_ready is low.
module systolic_seq_ctrl #(
  parameter int N = 4,
  parameter int K_WIDTH = 16,
  localparam int ROW_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [K_WIDTH-1:0]   k_len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 array_clr,
  output logic [N-1:0]         a_feed_vld,
  output logic [N*K_WIDTH-1:0] a_feed_k,
  output logic [N-1:0]         b_feed_vld,
  output logic [N*K_WIDTH-1:0] b_feed_k,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ROW_W-1:0]     res_row_sel,
  output logic                 res_last
);
  localparam int T_W = K_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, OUTPUT, FIN} state_t;

  state_t             state;
  logic [K_WIDTH-1:0] k_lat;
  logic [T_W-1:0]     t;
  logic [ROW_W-1:0]   row;
  logic [T_W-1:0]     t_end;
  logic [T_W-1:0]     d;
  logic               live_abort;
  logic               t_last;

  assign live_abort = abort && (state == CLEAR || state == FEED || state == OUTPUT);
  // Last FEED cycle: final product lands on PE(N-1,N-1) at t = k_len + 2N - 3.
  assign t_end  = {1'b0, k_lat} + T_W'(2 * N - 3);
  assign t_last = (t == t_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k_lat <= '0;
      t     <= '0;
      row   <= '0;
    end else if (live_abort) begin
      state <= FIN;
      t     <= '0;
      row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_lat <= k_len;
            t     <= '0;
            row   <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          t     <= '0;
          state <= (k_lat == '0) ? OUTPUT : FEED;
        end
        FEED: begin
          if (t_last) begin
            t     <= '0;
            state <= OUTPUT;
          end else begin
            t <= t + 1'b1;
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            if (row == ROW_W'(N - 1)) begin
              row   <= '0;
              state <= FIN;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        FIN: begin
          t     <= '0;
          row   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    a_feed_vld = '0;
    a_feed_k   = '0;
    d          = '0;
    for (int i = 0; i < N; i++) begin
      d = t - T_W'(i);
      if (state == FEED && !abort && t >= T_W'(i) && d < {1'b0, k_lat}) begin
        a_feed_vld[i]                  = 1'b1;
        a_feed_k[i*K_WIDTH +: K_WIDTH] = d[K_WIDTH-1:0];
      end
    end
  end

  // Column j uses the same skew as row i, so the B schedule mirrors A.
  assign b_feed_vld  = a_feed_vld;
  assign b_feed_k    = a_feed_k;

  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign array_clr   = (state == CLEAR) || live_abort;
  assign res_valid   = (state == OUTPUT) && !abort;
  assign res_row_sel = row;
  assign res_last    = res_valid && (row == ROW_W'(N - 1));

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: directed tiles push expected per-cycle events, a negedge monitor compares.
module tb_systolic_seq_ctrl;
  localparam int N  = 4;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          busy;
  logic          done;
  logic          array_clr;
  logic [N-1:0]  a_feed_vld;
  logic [N*KW-1:0] a_feed_k;
  logic [N-1:0]  b_feed_vld;
  logic [N*KW-1:0] b_feed_k;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_row_sel;
  logic          res_last;

  systolic_seq_ctrl #(.N(N), .K_WIDTH(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .array_clr(array_clr),
    .a_feed_vld(a_feed_vld), .a_feed_k(a_feed_k),
    .b_feed_vld(b_feed_vld), .b_feed_k(b_feed_k),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row_sel(res_row_sel), .res_last(res_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          rel;
    logic        clr;
    logic [3:0]  av;
    logic [63:0] ak;
    logic [3:0]  bv;
    logic [63:0] bk;
    logic        rv;
    logic [1:0]  row;
    logic        last;
    logic        dn;
    logic        bsy;
  } ev_t;

  ev_t expq[$];
  int  cyc = 0;
  int  st_cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  done_rel = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with visible activity must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t a;
    ev_t e;
    if (rst_n) begin
      a      = '0;
      a.rel  = cyc - st_cyc;
      a.clr  = array_clr;
      a.av   = a_feed_vld;
      a.ak   = a_feed_k;
      a.bv   = b_feed_vld;
      a.bk   = b_feed_k;
      a.rv   = res_valid;
      a.row  = res_row_sel;
      a.last = res_last;
      a.dn   = done;
      a.bsy  = busy;
      if (done) done_rel = a.rel;
      if (array_clr || a_feed_vld != 0 || b_feed_vld != 0 || res_valid || done) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event rel=%0d clr=%b av=%b rv=%b row=%0d done=%b", a.rel, a.clr, a.av, a.rv, a.row, a.dn);
        end else begin
          e = expq.pop_front();
          if (a !== e)begin
            errors++;
            $display("FAIL event got rel=%0d clr=%b av=%b ak=%h bv=%b bk=%h rv=%b row=%0d last=%b done=%b busy=%b | want rel=%0d clr=%b av=%b ak=%h bv=%b bk=%h rv=%b row=%0d last=%b done=%b busy=%b",
                     a.rel, a.clr, a.av, a.ak, a.bv, a.bk, a.rv, a.row, a.last, a.dn, a.bsy,
                     e.rel, e.clr, e.av, e.ak, e.bv, e.bk, e.rv, e.row, e.last, e.dn, e.bsy);
          end
        end
      end
    end
  end

  task automatic push_lim(input ev_t e, input int lim);
    if (e.rel < lim) expq.push_back(e);
  endtask

  // Expected events relative to the start cycle (rel 0): CLEAR at 1, FEED from 2.
  task automatic model(input int k, input int bp_s, input int bp_n, input int ab, input int rst, output int fin);
    ev_t e;
    int  rel;
    int  r;
    int  lim;
    lim = (ab > 0) ? ab : ((rst > 0) ? rst : 1000000);
    e = '0; e.bsy = 1'b1; e.rel = 1; e.clr = 1'b1;
    push_lim(e, lim);
    rel = 2;
    if (k > 0) begin
      for (int tt = 0; tt <= k + 2*N - 3; tt++) begin
        e = '0; e.bsy = 1'b1; e.rel = rel;
        for (int i = 0; i < N; i++) begin
          if (tt >= i && tt < i + k) begin
            e.av[i] = 1'b1;
            e.ak[i*KW +: KW] = 16'(tt - i);
          end
        end
        e.bv = e.av;
        e.bk = e.ak;
        if (e.av != 0) push_lim(e, lim);
        rel++;
      end
    end
    r = 0;
    while (r < N) begin
      e = '0; e.bsy = 1'b1; e.rel = rel; e.rv = 1'b1; e.row = 2'(r); e.last = (r == N-1);
      push_lim(e, lim);
      if (!(rel >= bp_s && rel < bp_s + bp_n)) r++;
      rel++;
    end
    e = '0; e.bsy = 1'b1; e.rel = rel; e.dn = 1'b1;
    push_lim(e, lim);
    fin = rel;
    if (ab > 0) begin
      e = '0; e.bsy = 1'b1; e.rel = ab; e.clr = 1'b1;
      expq.push_back(e);
      e = '0; e.bsy = 1'b1; e.rel = ab + 1; e.dn = 1'b1;
      expq.push_back(e);
      fin = ab + 1;
    end
    if (rst > 0) fin = rst + 4;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({busy, done, array_clr, a_feed_vld, b_feed_vld, a_feed_k, b_feed_k, res_valid, res_row_sel, res_last} !== '0) begin
      errors++;
      $display("FAIL %s outputs not zero: busy=%b done=%b clr=%b av=%b bv=%b rv=%b row=%0d last=%b (want all 0)",
               name, busy, done, array_clr, a_feed_vld, b_feed_vld, res_valid, res_row_sel, res_last);
    end
  endtask

  task automatic run_tile(input int k, input int bp_s, input int bp_n, input int ab,
                          input int st2, input int rst, input int exp_done);
    int fin;
    model(k, bp_s, bp_n, ab, rst, fin);
    done_rel = -1;
    @(posedge clk); #1;
    start  = 1'b1;
    k_len  = 16'(k);
    st_cyc = cyc;
    for (int r = 1; r <= fin + 2; r++) begin
      @(posedge clk); #1;
      start     = (r == st2);
      k_len     = 16'hFFFF;
      res_ready = !(r >= bp_s && r < bp_s + bp_n);
      abort     = (r == ab);
      if (rst > 0 && r == rst) begin
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
      end
      if (rst > 0 && r == rst + 2) rst_n = 1'b1;
    end
    abort     = 1'b0;
    start     = 1'b0;
    res_ready = 1'b1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL missing_events k=%0d got %0d pending want 0", k, expq.size());
    end
    expq.delete();
    checks++;
    if (done_rel != exp_done) begin
      errors++;
      $display("FAIL done_cycle k=%0d got rel=%0d want rel=%0d", k, done_rel, exp_done);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1; k_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk);
    //       k  bp_s bp_n ab st2 rst done
    run_tile(3, 0,   0,   0, 0,  0,  15);
    run_tile(1, 0,   0,   0, 5,  0,  13);
    run_tile(0, 0,   0,   0, 0,  0,  6);
    run_tile(3, 12,  5,   0, 0,  0,  20);
    run_tile(3, 0,   0,   6, 0,  0,  7);
    run_tile(2, 0,   0,   0, 0,  0,  14);
    run_tile(3, 0,   0,   0, 0,  4,  -1);
    run_tile(3, 0,   0,   0, 0,  0,  15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for the N x N output-stationary PE array in the Q-projection datapath.
- Per tile:
  - clears the array accumulators;
  - issues skewed row (A) and column (B) feed schedules to the operand buffers;
  - waits for the wavefront to drain;
  - streams the N result rows out under a valid/ready handshake.
- Operand muxes outside this block drive 0 into the array edge whenever the matching feed-valid bit is low. PEs therefore accumulate 0 on idle cycles, and sums hold after FEED.

Parameters:
- N, 4: array dimension, N >= 2.
- K_WIDTH, 16: width of k_len and of each feed index.
- ROW_W, $clog2(N): localparam, width of res_row_sel.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin tile; sampled only in IDLE.
- k_len  in  K_WIDTH  reduction length; latched on accepted start.
- abort  in  1  synchronous cancel of the current tile.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a tile completes or is aborted.
- array_clr  out  1  accumulator clear to the PE array, one cycle wide.
- a_feed_vld  out  N  bit i high: row i of A is fed this cycle.
- a_feed_k  out  N*K_WIDTH  slice i is the k index for row i; 0 when that row is invalid.
- b_feed_vld  out  N  bit j high: column j of B is fed this cycle.
- b_feed_k  out  N*K_WIDTH  slice j is the k index for column j; 0 when that column is invalid.
- res_valid  out  1  result row available.
- res_ready  in  1  consumer accepts the result row.
- res_row_sel  out  ROW_W  array row currently presented.
- res_last  out  1  high with res_valid on row N-1.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counters 0, every output 0.
- States: IDLE, CLEAR, FEED, OUTPUT, FIN.
- IDLE:
  - start=1 latches k_len and moves to CLEAR.
  - All other inputs are ignored.
  - start is ignored in every other state.
- CLEAR:
  - Exactly 1 cycle with array_clr=1.
  - Then FEED with cycle counter t=0; if latched k_len==0, go to OUTPUT instead.
- FEED:
  - Counter t is K_WIDTH+1 bits wide.
  - Row i valid iff i <= t < i+k_len, with a_feed_k[i]=t-i.
  - Column j valid iff j <= t < j+k_len, with b_feed_k[j]=t-j.
  - Feed outputs are combinational from t and state.
  - FEED lasts exactly k_len+2N-2 cycles (t = 0 .. k_len+2N-3). The last product reaches PE(N-1,N-1) at t=k_len+2N-3 and is accumulated on that edge.
  - Then OUTPUT.
- OUTPUT:
  - res_valid=1, starting at res_row_sel=0.
  - The row advances only on res_valid && res_ready.
  - res_last=1 while res_row_sel==N-1.
  - Handshake on the last row moves to FIN.
  - res_row_sel holds while res_ready is low; there is no timeout.
- FIN: done=1 for one cycle, busy=1, then IDLE.
- Abort:
  - abort=1 in CLEAR, FEED or OUTPUT: next state FIN.
  - The same cycle also asserts array_clr=1; res_valid and all feed valids drop to 0 in that cycle.
  - abort in IDLE or FIN has no effect.
  - abort has priority over the res handshake in the same cycle.
- Array reset: the PE array itself is reset by system reset. array_clr is the only clear issued between tiles.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse.
- Latency start->done with res_ready tied high: 1 (CLEAR) + (k_len+2N-2) (FEED) + N (OUTPUT) + 1 (FIN), counted from the cycle after start.

Test Plan:
- N=4, k_len=3, res_ready=1:
  - array_clr 1 cycle after start.
  - FEED 9 cycles. Row 2 valid at t=2,3,4 with k=0,1,2. Row 3 and column 3 valid at t=3..5.
  - 4 result rows 0..3, res_last on row 3, done at cycle 15 after start.
- N=4, k_len=1: every row/column valid exactly once (row i at t=i, k=0); FEED 7 cycles; done at cycle 13.
- k_len=0: CLEAR, then OUTPUT directly; no feed valid ever high; 4 rows (all-zero accumulators); done.
- Backpressure, k_len=3: res_ready low for 5 cycles on row 1 -> res_row_sel stays 1 with res_valid high; resumes on ready; done delayed by 5 cycles.
- abort at t=4 of FEED:
  - next cycle FIN with done=1.
  - array_clr=1 and feed valids 0 in the abort cycle.
  - No res_valid.
  - IDLE after, and a new start is accepted.
- start pulsed while busy -> ignored. rst_n low mid-FEED -> all outputs 0 asynchronously, no done; a fresh start after release runs a full tile correctly.
